sample_framer: RTL and testbench

Upstream feeder for `fft_256`. It collects a continuous stream of ADC samples into N-sample frames using two ping-pong banks. Once a frame is complete, it presents that frame on `time_samples` and pulses `start`. It holds the frame stable until `fft_256` reports `done`, while the other bank keeps filling.

---
 rtl/audio_pkg.sv | 23 ++
 rtl/sample_bank.sv | 36 +++
 rtl/sample_framer.sv | 142 ++++++++++++++
 tb/tb_sample_framer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared defaults, sample/frame types and framer state
//                encoding for the ADC-to-FFT front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int WIDTH     = 20;   // FFT computation width
    localparam int N         = 256;  // samples per frame (power of two)
    localparam int ADC_WIDTH = 12;   // raw ADC code width

    typedef logic [WIDTH-1:0] sample_t;
    typedef sample_t [0:N-1]  frame_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } framer_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sample_bank
//  Description : N-entry register bank with synchronous clear, one write
//                port and full-array readout.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_bank
    import audio_pkg::*;
#(
    parameter int WIDTH = audio_pkg::WIDTH,
    parameter int N     = audio_pkg::N
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we_i,
    input  logic [$clog2(N)-1:0]       addr_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [0:N-1][WIDTH-1:0]    data_o
);

    logic [0:N-1][WIDTH-1:0] bank_q;

    // Clear the whole bank on reset, otherwise write one entry when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= '0;
        end else if (we_i) begin
            bank_q[addr_i] <= data_i;
        end
    end

    assign data_o = bank_q;

endmodule
`default_nettype wire

// File: rtl/sample_framer.sv
`default_nettype none
// ============================================================================
//  Module      : sample_framer
//  Description : Collects ADC samples into N-sample frames using ping-pong
//                banks, hands completed frames to fft_256 with a start pulse
//                and holds them stable until fft_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_framer
    import audio_pkg::*;
#(
    parameter int WIDTH     = audio_pkg::WIDTH,
    parameter int N         = audio_pkg::N,
    parameter int ADC_WIDTH = audio_pkg::ADC_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid_i,
    input  logic [ADC_WIDTH-1:0]       sample_in_i,
    input  logic                       fft_done_i,
    output logic                       start_o,
    output logic [0:N-1][WIDTH-1:0]    time_samples_o,
    output logic                       fft_busy_o,
    output logic                       overrun_o,
    output logic [15:0]                drop_count_o
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    framer_state_t     state_q, state_d;
    logic              wr_sel_q, wr_sel_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       drop_q, drop_d;

    logic              swap;
    logic              accept;
    logic              drop;
    logic              we0, we1;
    logic [WIDTH-1:0]  wr_data;
    logic [0:N-1][WIDTH-1:0] bank0_data, bank1_data;

    // State and status registers; reset discards any partial frame and busy status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            wr_sel_q  <= 1'b0;
            wr_idx_q  <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_sel_q  <= wr_sel_d;
            wr_idx_q  <= wr_idx_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
        end
    end

    // Next-state logic: swap banks when a full frame waits and the FFT is free.
    always_comb begin
        state_d   = state_q;
        swap      = 1'b0;
        accept    = 1'b0;
        drop      = 1'b0;

        case (state_q)
            FILL: begin
                accept = sample_valid_i;
                if (sample_valid_i && (wr_idx_q == LAST_IDX)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                swap = !busy_q || fft_done_i;
                if (swap) begin
                    // A sample on the swap edge lands at index 0 of the new bank.
                    accept  = sample_valid_i;
                    state_d = FILL;
                end else begin
                    drop = sample_valid_i;
                end
            end
            default: state_d = FILL;
        endcase

        wr_sel_d  = swap ? ~wr_sel_q : wr_sel_q;
        wr_idx_d  = accept ? (wr_idx_q + IDX_W'(1)) : wr_idx_q;
        start_d   = swap;
        // Done with no swap on the same edge frees the FFT; done while idle is harmless.
        busy_d    = swap ? 1'b1 : (fft_done_i ? 1'b0 : busy_q);
        overrun_d = overrun_q | drop;
        drop_d    = (drop && (drop_q != 16'hFFFF)) ? (drop_q + 16'd1) : drop_q;
    end

    // Writes always target the post-swap fill bank so the read bank stays frozen.
    always_comb begin
        wr_data = WIDTH'(sample_in_i);
        we0     = accept && (wr_sel_d == 1'b0);
        we1     = accept && (wr_sel_d == 1'b1);
    end

    sample_bank #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_bank0 (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we0),
        .addr_i (wr_idx_q),
        .data_i (wr_data),
        .data_o (bank0_data)
    );

    sample_bank #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_bank1 (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we1),
        .addr_i (wr_idx_q),
        .data_i (wr_data),
        .data_o (bank1_data)
    );

    // The read bank is always the one not being filled.
    assign time_samples_o = wr_sel_q ? bank0_data : bank1_data;
    assign start_o        = start_q;
    assign fft_busy_o     = busy_q;
    assign overrun_o      = overrun_q;
    assign drop_count_o   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_framer
//  Description : Directed self-checking bench for sample_framer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_framer;

    localparam int WIDTH     = 20;
    localparam int N         = 256;
    localparam int ADC_WIDTH = 12;

    logic                     clk;
    logic                     rst;
    logic                     sample_valid;
    logic [ADC_WIDTH-1:0]     sample_in;
    logic                     fft_done;
    logic                     start;
    logic [0:N-1][WIDTH-1:0]  time_samples;
    logic                     fft_busy;
    logic                     overrun;
    logic [15:0]              drop_count;

    int vectors    = 0;
    int miscompares = 0;
    int starts     = 0;
    logic hold_ok;

    sample_framer #(
        .WIDTH     (WIDTH),
        .N         (N),
        .ADC_WIDTH (ADC_WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_valid_i (sample_valid),
        .sample_in_i    (sample_in),
        .fft_done_i     (fft_done),
        .start_o        (start),
        .time_samples_o (time_samples),
        .fft_busy_o     (fft_busy),
        .overrun_o      (overrun),
        .drop_count_o   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one clock edge, then observe 1 time unit after it.
    task automatic cyc(input logic v, input logic [ADC_WIDTH-1:0] d, input logic done);
        sample_valid = v;
        sample_in    = d;
        fft_done     = done;
        @(posedge clk);
        #1;
        if (start === 1'b1) starts++;
    endtask

    initial begin
        rst = 1'b1;
        sample_valid = 1'b0;
        sample_in = '0;
        fft_done = 1'b0;

        // ---- Reset state ----
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        rst = 1'b0;
        chk("rst_start",   32'(start),      32'd0);
        chk("rst_busy",    32'(fft_busy),   32'd0);
        chk("rst_overrun", 32'(overrun),    32'd0);
        chk("rst_drops",   32'(drop_count), 32'd0);
        chk("rst_ts_zero", 32'(time_samples === '0), 32'd1);

        // ---- Spurious done while idle ----
        starts = 0;
        cyc(0, 0, 1);
        chk("spur_busy",  32'(fft_busy), 32'd0);
        chk("spur_start", 32'(start),    32'd0);
        cyc(0, 0, 0);
        chk("spur_starts", 32'(starts), 32'd0);

        // ---- Fill after reset: values 1..256 ----
        starts = 0;
        for (int i = 0; i < N; i++) cyc(1, ADC_WIDTH'(i + 1), 0);
        chk("fill_no_early_start", 32'(starts), 32'd0);
        // 257th sample (4095) arrives on the swap edge -> index 0 of the new bank
        cyc(1, 12'hFFF, 0);
        chk("fill_start",    32'(start),            32'd1);
        chk("fill_starts",   32'(starts),           32'd1);
        chk("fill_ts0",      32'(time_samples[0]),  32'd1);
        chk("fill_ts255",    32'(time_samples[255]),32'd256);
        chk("fill_busy",     32'(fft_busy),         32'd1);

        // ---- Back-pressure: 300 more samples, FFT still busy ----
        starts  = 0;
        hold_ok = 1'b1;
        for (int j = 0; j < 300; j++) begin
            cyc(1, ADC_WIDTH'(2000 + j), 0);
            if (time_samples[0] !== 20'd1 || time_samples[255] !== 20'd256 ||
                time_samples[128] !== 20'd129) hold_ok = 1'b0;
        end
        chk("bp_ts_stable", 32'(hold_ok),    32'd1);
        chk("bp_starts",    32'(starts),     32'd0);
        chk("bp_overrun",   32'(overrun),    32'd1);
        chk("bp_drops",     32'(drop_count), 32'd45);
        chk("bp_busy",      32'(fft_busy),   32'd1);

        // ---- Swap on done, carrying sample 7 ----
        cyc(1, 12'd7, 1);
        chk("swap_start",  32'(start),             32'd1);
        chk("swap_zext",   32'(time_samples[0]),   32'h00FFF);
        chk("swap_ts1",    32'(time_samples[1]),   32'd2000);
        chk("swap_ts255",  32'(time_samples[255]), 32'd2254);
        chk("swap_busy",   32'(fft_busy),          32'd1);
        chk("swap_drops",  32'(drop_count),        32'd45);
        cyc(0, 0, 0);
        chk("swap_start_once", 32'(start), 32'd0);

        // Finish the third frame (index 0 already holds 7), then release it
        for (int k = 1; k < N; k++) cyc(1, ADC_WIDTH'(100 + k), 0);
        cyc(0, 0, 1);
        chk("third_start", 32'(start),             32'd1);
        chk("third_ts0",   32'(time_samples[0]),   32'd7);
        chk("third_ts1",   32'(time_samples[1]),   32'd101);
        chk("third_ts255", 32'(time_samples[255]), 32'd355);

        // ---- Reset mid-operation at sample 100 while busy ----
        for (int k = 0; k < 99; k++) cyc(1, ADC_WIDTH'(k + 500), 0);
        chk("mid_busy_before", 32'(fft_busy), 32'd1);
        rst = 1'b1;
        cyc(1, 12'd50, 0);
        rst = 1'b0;
        chk("mid_start",   32'(start),      32'd0);
        chk("mid_busy",    32'(fft_busy),   32'd0);
        chk("mid_overrun", 32'(overrun),    32'd0);
        chk("mid_drops",   32'(drop_count), 32'd0);
        chk("mid_ts_zero", 32'(time_samples === '0), 32'd1);

        starts = 0;
        for (int i = 0; i < N; i++) cyc(1, ADC_WIDTH'(i + 1), 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("post_rst_starts", 32'(starts),             32'd1);
        chk("post_rst_ts0",    32'(time_samples[0]),    32'd1);
        chk("post_rst_ts255",  32'(time_samples[255]),  32'd256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
